// File: rtl/vga_piano_renderer.sv
// vga_piano_renderer: 640x480 VGA timing generator drawing a sky band over a piano keyboard
// Ports: clk pixel clock; reset async active-high; key_pressed per-key flags;
//        hsync/vsync active-low syncs; sync_b tied 0; blank_b high on visible pixels;
//        red/green/blue pixel colour; frame_start one-cycle pulse on pixel (0,0).
// Macro VGA_PIANO_HILITE_EN enables pressed-key highlighting (latched once per frame).
// Outputs lag the counters by exactly two clocks (decode stage, colour stage).
module vga_piano_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int NUM_KEYS = 7,
  parameter int KEY_W = 90,
  parameter int SKY_H = 192,
  parameter int BKEY_BOTTOM = 400,
  parameter int BKEY_HALF = 25,
  parameter logic [NUM_KEYS-1:0] BKEY_MASK = 7'b1110110,
  parameter logic [23:0] SKY_RGB = 24'hDAE8FC,
  parameter logic [23:0] HILITE_RGB = 24'h80C0FF
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_KEYS-1:0] key_pressed,
  output logic hsync,
  output logic vsync,
  output logic sync_b,
  output logic blank_b,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int KW = $clog2(KEY_W);
  localparam int IW = $clog2(NUM_KEYS + 1);
  localparam int MW = NUM_KEYS + 2;
  // Two zero pad bits so boundaries past the last key never carry a black key.
  localparam logic [MW-1:0] MASK = {2'b00, BKEY_MASK};
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [KW-1:0] kofs;
  logic [IW-1:0] kidx;
  logic h_end, v_end, k_end;
  logic [MW-1:0] sel;
  logic vis, sky, line, bkey, press, hs, vs, fs;
  logic s1_vis, s1_sky, s1_line, s1_bkey, s1_press, s1_hs, s1_vs, s1_fs;
  logic s2_vis, s2_hs, s2_vs, s2_fs;
  logic [23:0] rgb;
  assign h_end = hcnt == HW'(H_TOTAL - 1);
  assign v_end = vcnt == VW'(V_TOTAL - 1);
  assign k_end = kofs == KW'(KEY_W - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
      kofs <= '0;
      kidx <= '0;
    end else begin
      hcnt <= h_end ? '0 : hcnt + 1'b1;
      vcnt <= h_end ? (v_end ? '0 : vcnt + 1'b1) : vcnt;
      kofs <= (h_end || k_end) ? '0 : kofs + 1'b1;
      kidx <= h_end ? '0 : (k_end && kidx != IW'(NUM_KEYS)) ? kidx + 1'b1 : kidx;
    end
`ifdef VGA_PIANO_HILITE_EN
  // Latched on the last pixel of the frame so a whole frame shows one key snapshot.
  logic [NUM_KEYS-1:0] frame_keys;
  always_ff @(posedge clk or posedge reset)
    if (reset) frame_keys <= '0;
    else if (h_end && v_end) frame_keys <= key_pressed;
  assign press = |(frame_keys & sel[NUM_KEYS-1:0]);
`else
  logic unused_keys;
  assign unused_keys = ^key_pressed;
  assign press = 1'b0;
`endif
  always_comb begin
    sel = MW'(1) << kidx;
    vis = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
    sky = vcnt < VW'(SKY_H);
    line = vcnt == VW'(SKY_H) || (vcnt > VW'(SKY_H) && kofs == '0) || hcnt == HW'(H_ACTIVE - 1);
    bkey = vcnt > VW'(SKY_H) && vcnt <= VW'(BKEY_BOTTOM) &&
           ((kofs < KW'(BKEY_HALF) && |(MASK & sel)) ||
            (kofs >= KW'(KEY_W - BKEY_HALF) && |(MASK & (sel << 1))));
    hs = hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC);
    vs = vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC);
    fs = hcnt == '0 && vcnt == '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {s1_vis, s1_sky, s1_line, s1_bkey, s1_press, s1_hs, s1_vs, s1_fs} <= '0;
      {s2_vis, s2_hs, s2_vs, s2_fs} <= '0;
      rgb <= '0;
    end else begin
      {s1_vis, s1_sky, s1_line, s1_bkey, s1_press, s1_hs, s1_vs, s1_fs} <= {vis, sky, line, bkey, press, hs, vs, fs};
      {s2_vis, s2_hs, s2_vs, s2_fs} <= {s1_vis, s1_hs, s1_vs, s1_fs};
      rgb <= !s1_vis ? 24'h000000 : s1_sky ? SKY_RGB : (s1_line || s1_bkey) ? 24'h000000 :
             s1_press ? HILITE_RGB : 24'hFFFFFF;
    end
  // Sync stages hold "in sync pulse" so a cleared register reads as an idle-high output.
  assign hsync = ~s2_hs;
  assign vsync = ~s2_vs;
  assign sync_b = 1'b0;
  assign blank_b = s2_vis;
  assign frame_start = s2_fs;
  assign {red, green, blue} = rgb;
endmodule

// File: tb/tb_vga_piano_renderer.sv
// tb_vga_piano_renderer: directed vector bench on a shrunken raster (180x88, 20-px keys)
module tb_vga_piano_renderer;
  localparam int HA = 150, HF = 4, HS = 10, HB = 16, HT = HA + HF + HS + HB;
  localparam int VA = 80, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;
  localparam int F = HT * VT;
  localparam logic [23:0] SKYC = 24'hDAE8FC, WH = 24'hFFFFFF, BK = 24'h000000;
`ifdef VGA_PIANO_HILITE_EN
  localparam logic [23:0] PR = 24'h80C0FF;
`else
  localparam logic [23:0] PR = 24'hFFFFFF;
`endif
  logic clk = 0, reset = 1;
  logic [6:0] key_pressed = 7'b0000100;
  logic hsync, vsync, sync_b, blank_b, frame_start;
  logic [7:0] red, green, blue;
  int total = 0, bad = 0;
  int n;
  logic hs_p = 1, vs_p = 1;
  int hs_f = -1, hs_per = 0, hs_low = 0, hs_pos = -1;
  int vs_f = -1, vs_per = 0, vs_low = 0, vs_pos = -1;
  typedef struct {
    int f, h, v;
    logic [23:0] rgb;
    logic bl;
    logic [6:0] kp;
  } vec_t;
  vec_t tab [20];
  vga_piano_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .KEY_W(20), .SKY_H(32), .BKEY_BOTTOM(64), .BKEY_HALF(6)
  ) dut (
    .clk(clk), .reset(reset), .key_pressed(key_pressed),
    .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  // n = linear index of the pixel currently presented at the outputs
  always @(posedge clk or posedge reset)
    if (reset) n <= -2;
    else n <= n + 1;
  always @(negedge clk)
    if (n >= 0) begin
      if (hs_p && !hsync) begin
        if (hs_f >= 0) hs_per = n - hs_f;
        hs_f = n;
        hs_pos = n % HT;
      end
      if (!hs_p && hsync && hs_f >= 0) hs_low = n - hs_f;
      if (vs_p && !vsync) begin
        if (vs_f >= 0) vs_per = n - vs_f;
        vs_f = n;
        vs_pos = n % F;
      end
      if (!vs_p && vsync && vs_f >= 0) vs_low = n - vs_f;
      hs_p = hsync;
      vs_p = vsync;
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic at_pix(input int t);
    int b;
    b = t - n + 4;
    while (n != t && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (n != t) chk("timeout", n, t);
  endtask
  task automatic check_reset_vals(input string nm);
    chk({nm, "_hsync"}, hsync, 1);
    chk({nm, "_vsync"}, vsync, 1);
    chk({nm, "_blank"}, blank_b, 0);
    chk({nm, "_rgb"}, {red, green, blue}, 0);
    chk({nm, "_fs"}, frame_start, 0);
  endtask
  task automatic release_chk(input string nm);
    @(negedge clk) reset = 0;
    @(posedge clk) #1 chk({nm, "_fs_e1"}, frame_start, 0);
    @(posedge clk) #1;
    chk({nm, "_fs_e2"}, frame_start, 1);
    chk({nm, "_blank00"}, blank_b, 1);
    chk({nm, "_rgb00"}, {red, green, blue}, SKYC);
    @(posedge clk) #1 chk({nm, "_fs_e3"}, frame_start, 0);
  endtask
  initial begin
    tab[0]  = '{0, 10, 10, SKYC, 1'b1, 7'b0000100};
    tab[1]  = '{0, 50, 32, BK, 1'b1, 7'b0000100};
    tab[2]  = '{0, 20, 50, BK, 1'b1, 7'b0000100};
    tab[3]  = '{0, 25, 50, BK, 1'b1, 7'b0000100};
    tab[4]  = '{0, 35, 50, BK, 1'b1, 7'b0000100};
    tab[5]  = '{0, 70, 50, WH, 1'b1, 7'b0000100};
    tab[6]  = '{0, 130, 50, WH, 1'b1, 7'b0000100};
    tab[7]  = '{0, 135, 50, WH, 1'b1, 7'b0000100};
    tab[8]  = '{0, 141, 50, WH, 1'b1, 7'b0000100};
    tab[9]  = '{0, 149, 50, BK, 1'b1, 7'b0000100};
    tab[10] = '{0, 160, 50, BK, 1'b0, 7'b0000100};
    tab[11] = '{0, 45, 70, WH, 1'b1, 7'b0000100};
    tab[12] = '{0, 10, 85, BK, 1'b0, 7'b0000100};
    tab[13] = '{1, 45, 50, BK, 1'b1, 7'b0000100};
    tab[14] = '{1, 45, 70, PR, 1'b1, 7'b0000100};
    tab[15] = '{1, 65, 70, WH, 1'b1, 7'b0001000};
    tab[16] = '{1, 45, 75, PR, 1'b1, 7'b0001000};
    tab[17] = '{1, 65, 75, WH, 1'b1, 7'b0001000};
    tab[18] = '{2, 45, 70, WH, 1'b1, 7'b0001000};
    tab[19] = '{2, 65, 70, PR, 1'b1, 7'b0001000};
    repeat (3) @(posedge clk);
    #1 check_reset_vals("in_reset");
    chk("sync_b", sync_b, 0);
    release_chk("rel1");
    for (int i = 0; i < 20; i++) begin
      at_pix(tab[i].f * F + tab[i].v * HT + tab[i].h);
      chk($sformatf("v%0d_rgb", i), {red, green, blue}, tab[i].rgb);
      chk($sformatf("v%0d_blank", i), blank_b, tab[i].bl);
      key_pressed = tab[i].kp;
    end
    chk("hs_period", hs_per, HT);
    chk("hs_low", hs_low, HS);
    chk("hs_pos", hs_pos, HA + HF);
    chk("vs_period", vs_per, F);
    chk("vs_low", vs_low, VS * HT);
    chk("vs_pos", vs_pos, (VA + VF) * HT);
    reset = 1;
    #1 check_reset_vals("midreset_vis");
    repeat (2) @(posedge clk);
    release_chk("rel2");
    at_pix(50 * HT + 25);
    chk("restart_bkey", {red, green, blue}, BK);
    chk("restart_blank", blank_b, 1);
    at_pix((VA + VF) * HT + HA + HF + 2);
    chk("pre_hsync", hsync, 0);
    chk("pre_vsync", vsync, 0);
    reset = 1;
    #1 check_reset_vals("midreset_sync");
    repeat (2) @(posedge clk);
    release_chk("rel3");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
